// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial sharing of the unified RAM port between instruction fetch and MEM.
// Optional macro IO_BUF_WAIT_EN: IO-region store bytes wait while io_buffer_full is set.
module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  input  logic              failed,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [2:0] {IDLE, IF_READ, MEM_READ, MEM_WRITE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] next_a;
  logic [2:0]        nbytes;
  logic [2:0]        cnt;
  logic [2:0]        cnt_inc;
  logic [31:0]       wdata;
  logic [31:0]       asm_q;
  logic [31:0]       asm_nxt;
  logic              is_if;
  logic              wr_q;
  logic              io_stall;

  function automatic logic [2:0] byte_count(input logic [2:0] len);
    case (len)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] d, input logic [2:0] idx);
    case (idx)
      3'd1:    return d[15:8];
      3'd2:    return d[23:16];
      3'd3:    return d[31:24];
      default: return d[7:0];
    endcase
  endfunction

  assign cnt_inc = cnt + 3'd1;
  assign next_a  = base + ADDR_W'(cnt_inc);

`ifdef IO_BUF_WAIT_EN
  assign io_stall = (state == MEM_WRITE) && (ram_a[17:16] == IO_HI) && io_buffer_full;
`else
  // io_buffer_full has no effect in this build
  assign io_stall = 1'b0 & io_buffer_full;
`endif

  // The strobe is the only output gated combinationally: a frozen or stalled cycle must not write
  assign ram_wr = wr_q & rdy & ~io_stall;

  // Read byte arriving this cycle belongs to the address issued one count earlier
  always_comb begin
    asm_nxt = asm_q;
    case (cnt)
      3'd1:    asm_nxt[7:0]   = ram_din;
      3'd2:    asm_nxt[15:8]  = ram_din;
      3'd3:    asm_nxt[23:16] = ram_din;
      3'd4:    asm_nxt[31:24] = ram_din;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ram_a     <= '0;
      ram_dout  <= '0;
      wr_q      <= 1'b0;
      if_data   <= '0;
      if_done   <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
      cnt       <= '0;
      asm_q     <= '0;
      base      <= '0;
      nbytes    <= '0;
      wdata     <= '0;
      is_if     <= 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          asm_q <= '0;
          if (mem_req) begin
            base   <= mem_addr;
            ram_a  <= mem_addr;
            nbytes <= byte_count(mem_len);
            is_if  <= 1'b0;
            if (mem_we) begin
              wdata    <= mem_wdata;
              ram_dout <= mem_wdata[7:0];
              wr_q     <= 1'b1;
              state    <= MEM_WRITE;
            end else begin
              state <= MEM_READ;
            end
          end else if (if_req && !failed) begin
            base   <= if_addr;
            ram_a  <= if_addr;
            nbytes <= 3'd4;
            is_if  <= 1'b1;
            state  <= IF_READ;
          end
        end
        IF_READ, MEM_READ: begin
          if (state == IF_READ && failed) begin
            state <= IDLE;
            ram_a <= '0;
            cnt   <= '0;
          end else begin
            asm_q <= asm_nxt;
            if (cnt == nbytes) begin
              state <= DONE;
              if (is_if) begin
                if_data <= asm_nxt;
                if_done <= 1'b1;
              end else begin
                mem_rdata <= asm_nxt;
                mem_done  <= 1'b1;
              end
            end else begin
              cnt   <= cnt_inc;
              ram_a <= (cnt_inc < nbytes) ? next_a : '0;
            end
          end
        end
        MEM_WRITE: begin
          if (!io_stall) begin
            if (cnt_inc == nbytes) begin
              state    <= DONE;
              mem_done <= 1'b1;
              wr_q     <= 1'b0;
              ram_a    <= '0;
            end else begin
              cnt      <= cnt_inc;
              ram_a    <= next_a;
              ram_dout <= pick_byte(wdata, cnt_inc);
            end
          end
        end
        DONE: begin
          if_done  <= 1'b0;
          mem_done <= 1'b0;
          cnt      <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level RAM model predicts read data and write traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, if_req, mem_req, mem_we, failed, io_buffer_full;
  logic [2:0]  mem_len;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_data, mem_rdata, ram_a;
  logic        if_done, mem_done, ram_wr;
  logic [7:0]  ram_din, ram_dout;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .failed(failed), .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a),
    .ram_wr(ram_wr), .io_buffer_full(io_buffer_full)
  );

  // Physical RAM (written by the DUT) and reference image (written by the model); both alias on addr[15:0].
  // The RAM's read register shares the global enable, so it freezes with rdy like the rest of the system.
  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (rdy) ram_din <= ram[ram_a[15:0]];
    if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
  end

  typedef struct packed { logic [31:0] a; logic [7:0] d; } wexp_t;
  typedef struct packed { logic st; logic [31:0] d; } mexp_t;

  wexp_t       exp_wr[$];
  mexp_t       exp_mem[$];
  logic [31:0] exp_if[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int nb(input logic [2:0] len);
    return (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] r, x;
    r = '0;
    for (int k = 0; k < n; k++) begin
      x = a + 32'(k);
      r[8*k +: 8] = ref_mem[x[15:0]];
    end
    return r;
  endfunction

  task automatic expect_write(input logic [31:0] a, input logic [31:0] wd, input int n);
    wexp_t w;
    for (int k = 0; k < n; k++) begin
      w.a = a + 32'(k);
      w.d = wd[8*k +: 8];
      exp_wr.push_back(w);
      ref_mem[w.a[15:0]] = w.d;
    end
  endtask

  // Monitor: every write strobe and every rising done edge is matched against the scoreboard
  logic if_done_q = 1'b0;
  logic mem_done_q = 1'b0;
  always @(negedge clk) begin
    wexp_t w;
    mexp_t m;
    if (ram_wr) begin
      if (exp_wr.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got a=0x%0h d=0x%0h expected no write", ram_a, ram_dout);
      end else begin
        w = exp_wr.pop_front();
        chk("wr_addr", ram_a, w.a);
        chk("wr_data", {24'h0, ram_dout}, {24'h0, w.d});
      end
    end
    if (if_done && !if_done_q) begin
      if (exp_if.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_if_done: got data 0x%0h expected no pulse", if_data);
      end else chk("if_data", if_data, exp_if.pop_front());
    end
    if (mem_done && !mem_done_q) begin
      if (exp_mem.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_mem_done: got data 0x%0h expected no pulse", mem_rdata);
      end else begin
        m = exp_mem.pop_front();
        if (!m.st) chk("mem_rdata", mem_rdata, m.d);
      end
    end
    if_done_q  <= if_done;
    mem_done_q <= mem_done;
  end

  task automatic run_access(input bit is_if, input bit we, input logic [2:0] len,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int fs, input int fail_at, input bit trace,
                            output logic [31:0] rd);
    int n, lat;
    bit got;
    logic [31:0] x;
    mexp_t m;
    n = is_if ? 4 : nb(len);
    if (is_if) exp_if.push_back(ref_read(addr, n));
    else if (we) begin
      expect_write(addr, wd, n);
      m.st = 1'b1; m.d = '0;
      exp_mem.push_back(m);
    end else begin
      m.st = 1'b0; m.d = ref_read(addr, n);
      exp_mem.push_back(m);
    end
    lat = (!is_if && we) ? n + 1 : n + 2;
    if (fs > 0) lat += 2;
    @(posedge clk); #1;
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wd;
    end
    got = 1'b0;
    rd  = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (trace && fs == 0 && cyc >= 1 && cyc <= n) begin
        x = addr + 32'(cyc - 1);
        chk("trace_ram_a", ram_a, x);
        if (we && !is_if) begin
          chk("trace_ram_wr", {31'h0, ram_wr}, 32'h1);
          chk("trace_ram_dout", {24'h0, ram_dout}, {24'h0, wd[8*(cyc-1) +: 8]});
        end
      end
      if ((is_if && if_done) || (!is_if && mem_done)) begin
        got = 1'b1;
        rd  = is_if ? if_data : mem_rdata;
        chk("done_latency", cyc, lat);
        chk("done_ram_a", ram_a, 32'h0);
        chk("done_ram_wr", {31'h0, ram_wr}, 32'h0);
      end
      @(posedge clk); #1;
      if (got) break;
      if (fs > 0 && cyc + 1 == fs) rdy = 1'b0;
      if (fs > 0 && cyc + 1 == fs + 2) rdy = 1'b1;
      failed = is_if ? (cyc + 1 == fail_at) : 1'($urandom_range(0, 1));
`ifndef IO_BUF_WAIT_EN
      io_buffer_full = 1'($urandom_range(0, 1));
`endif
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done pulse expected one after %0d cycles", lat);
    end
    if_req = 1'b0; mem_req = 1'b0; failed = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d0, wd, a;
    logic [7:0]  b;
    int md, id, wc, kind, n, fs;
    bit seen;
    mexp_t m;

    rst = 1'b1; rdy = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; failed = 1'b0;
    io_buffer_full = 1'b0; mem_len = '0; if_addr = '0; mem_addr = '0; mem_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      ram[i] = b;
      ref_mem[i] = b;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
    chk("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_dones", {30'h0, if_done, mem_done}, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Instruction fetch of a known word
    ram[16'h100] = 8'h13; ram[16'h101] = 8'h05; ram[16'h102] = 8'h00; ram[16'h103] = 8'h00;
    ref_mem[16'h100] = 8'h13; ref_mem[16'h101] = 8'h05; ref_mem[16'h102] = 8'h00; ref_mem[16'h103] = 8'h00;
    run_access(1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 0, 0, 1'b1, d);
    chk("fetch_word", d, 32'h00000513);

    // Simultaneous requests: MEM first, IF right after its DONE
    ram[16'h2000] = 8'hFF; ref_mem[16'h2000] = 8'hFF;
    m.st = 1'b0; m.d = 32'hFF;
    exp_mem.push_back(m);
    exp_if.push_back(ref_read(32'h300, 4));
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 3'd1; mem_addr = 32'h2000;
    if_req = 1'b1; if_addr = 32'h300;
    md = -1; id = -1;
    for (int cyc = 0; cyc < 40 && id < 0; cyc++) begin
      @(negedge clk);
      if (mem_done && md < 0) begin
        md = cyc;
        chk("arb_mem_rdata", mem_rdata, 32'hFF);
      end
      if (cyc == 5) chk("arb_if_ram_a", ram_a, 32'h300);
      if (if_done && id < 0) id = cyc;
      @(posedge clk); #1;
      if (md == cyc) mem_req = 1'b0;
      if (id >= 0) if_req = 1'b0;
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("arb_mem_first", md, 32'd3);
    chk("arb_if_after", id, 32'd10);

    // Two-byte store, then read back the whole word
    run_access(1'b0, 1'b1, 3'd2, 32'h40, 32'hAABBCCDD, 0, 0, 1'b1, d);
    run_access(1'b0, 1'b0, 3'd4, 32'h40, 32'h0, 0, 0, 1'b1, d);

    // Mispredict during a fetch; a waiting load is granted in the following IDLE cycle
    m.st = 1'b0; m.d = ref_read(32'h2000, 1);
    exp_mem.push_back(m);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h500;
    seen = 1'b0; md = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (if_done) seen = 1'b1;
      if (cyc == 3) chk("fail_idle_ram_a", ram_a, 32'h0);
      if (mem_done && md < 0) md = cyc;
      @(posedge clk); #1;
      if (cyc == 1) begin
        failed = 1'b1; if_req = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 3'd1; mem_addr = 32'h2000;
      end
      if (cyc == 2) failed = 1'b0;
      if (md >= 0) begin
        mem_req = 1'b0;
        break;
      end
    end
    mem_req = 1'b0;
    chk("fail_no_if_done", {31'h0, seen}, 32'h0);
    chk("fail_mem_latency", md, 32'd6);

    // Reset in the third byte of a four-byte store
    wd = $urandom;
    expect_write(32'h600, wd, 3);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 3'd4; mem_addr = 32'h600; mem_wdata = wd;
    seen = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (mem_done) seen = 1'b1;
      if (cyc == 4) begin
        chk("mid_rst_ram_a", ram_a, 32'h0);
        chk("mid_rst_ram_wr", {31'h0, ram_wr}, 32'h0);
        chk("mid_rst_ram_dout", {24'h0, ram_dout}, 32'h0);
        chk("mid_rst_if_data", if_data, 32'h0);
        chk("mid_rst_mem_rdata", mem_rdata, 32'h0);
      end
      @(posedge clk); #1;
      if (cyc == 2) begin
        rst = 1'b1; mem_req = 1'b0;
      end
      if (cyc == 3) rst = 1'b0;
    end
    chk("mid_rst_no_done", {31'h0, seen}, 32'h0);

    // Global-enable freeze mid-read must only delay completion
    run_access(1'b0, 1'b0, 3'd4, 32'h1234, 32'h0, 0, 0, 1'b1, d0);
    run_access(1'b0, 1'b0, 3'd4, 32'h1234, 32'h0, 2, 0, 1'b0, d);
    chk("freeze_same_data", d, d0);
    run_access(1'b1, 1'b0, 3'd0, 32'h1300, 32'h0, 3, 0, 1'b0, d);
    run_access(1'b0, 1'b1, 3'd4, 32'h1400, 32'h11223344, 2, 0, 1'b0, d);

    // Mispredict in the DONE cycle still delivers the fetch
    run_access(1'b1, 1'b0, 3'd0, 32'h200, 32'h0, 0, 6, 1'b1, d);

    // Address wrap and illegal lengths
    run_access(1'b0, 1'b1, 3'd4, 32'hFFFFFFFE, 32'h5A6B7C8D, 0, 0, 1'b1, d);
    run_access(1'b0, 1'b0, 3'd4, 32'hFFFFFFFE, 32'h0, 0, 0, 1'b1, d);
    run_access(1'b0, 1'b0, 3'd3, 32'h0800, 32'h0, 0, 0, 1'b1, d);
    run_access(1'b0, 1'b1, 3'd0, 32'h0900, 32'hCAFEF00D, 0, 0, 1'b1, d);
    run_access(1'b0, 1'b0, 3'd7, 32'h0900, 32'h0, 0, 0, 1'b1, d);

    // One-byte IO store while the IO buffer reports full for three cycles
    wd = $urandom;
    expect_write(32'h30000, wd, 1);
    m.st = 1'b1; m.d = '0;
    exp_mem.push_back(m);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 3'd1; mem_addr = 32'h30000; mem_wdata = wd;
    io_buffer_full = 1'b1;
    wc = -1; md = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (ram_wr && wc < 0) wc = cyc;
      if (mem_done && md < 0) md = cyc;
      @(posedge clk); #1;
      if (cyc == 3) io_buffer_full = 1'b0;
      if (md >= 0) break;
    end
    mem_req = 1'b0; io_buffer_full = 1'b0;
`ifdef IO_BUF_WAIT_EN
    chk("io_write_cycle", wc, 32'd4);
    chk("io_done_cycle", md, 32'd5);
`else
    chk("io_write_cycle", wc, 32'd1);
    chk("io_done_cycle", md, 32'd2);
`endif

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      mem_len = 3'($urandom_range(0, 7));
      a = $urandom;
      if (i % 8 == 0) a = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
      n = (kind == 0) ? 4 : nb(mem_len);
      fs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
      run_access(kind == 0, kind == 2, mem_len, a, $urandom, fs, 0, 1'b1, d);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pending_writes", exp_wr.size(), 32'd0);
    chk("pending_mem", exp_mem.size(), 32'd0);
    chk("pending_if", exp_if.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
